// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch sequencer generating every 8-bit PC control strobe
//
// Inputs : seq_clk, seq_rst_n (async, active low), seq_start, seq_halt_req,
//          mem_ready, ir_in[15:0], flag_z, exec_done
// Outputs: pc_rd_en, pc_wr_en, pc_count, pc_dir, pc_load_sel, mem_rd_req,
//          ir_load, exec_start, seq_busy, seq_halted, seq_fault
// All outputs are flops loaded from a decode of the next state, so each one
// is high exactly while the FSM sits in the state that owns it.
module pc_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPC_W       = 4
) (
  input  logic        seq_clk,
  input  logic        seq_rst_n,
  input  logic        seq_start,
  input  logic        seq_halt_req,
  input  logic        mem_ready,
  input  logic [15:0] ir_in,
  input  logic        flag_z,
  input  logic        exec_done,
  output logic        pc_rd_en,
  output logic        pc_wr_en,
  output logic        pc_count,
  output logic        pc_dir,
  output logic        pc_load_sel,
  output logic        mem_rd_req,
  output logic        ir_load,
  output logic        exec_start,
  output logic        seq_busy,
  output logic        seq_halted,
  output logic        seq_fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_MEMWAIT, S_LOADIR, S_DECODE, S_OPFETCH, S_OPWAIT,
    S_JLOAD, S_BRLOAD, S_STEP, S_EXEC, S_EXWAIT, S_HALT, S_FAULT
  } state_t;

  localparam logic [7:0]       TO_LAST   = 8'(MEM_TIMEOUT - 1);
  localparam logic [OPC_W-1:0] OPC_HALT  = OPC_W'(4'hF);
  localparam logic [OPC_W-1:0] OPC_JMP   = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OPC_BRZ   = OPC_W'(4'hD);
  localparam logic [OPC_W-1:0] OPC_BSTEP = OPC_W'(4'hC);

  state_t           state, nxt;
  logic [7:0]       to_cnt, to_nxt;
  logic [3:0]       step_cnt, step_nxt;
  logic             fetch_halt, fetch_halt_d;
  logic             rd_d, wr_d, cnt_d, dir_d, lsel_d, mrq_d, irl_d, exs_d;
  logic             busy_d, halted_d, fault_d;
  logic [OPC_W-1:0] opcode;
  logic             ir_unused;

  assign opcode    = ir_in[15 -: OPC_W];
  assign ir_unused = ^ir_in[15-OPC_W:4];

  always_comb begin
    nxt          = state;
    to_nxt       = to_cnt;
    step_nxt     = step_cnt;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    cnt_d        = 1'b0;
    dir_d        = 1'b0;
    lsel_d       = 1'b0;
    mrq_d        = 1'b0;
    irl_d        = 1'b0;
    exs_d        = 1'b0;
    halted_d     = 1'b0;
    fault_d      = 1'b0;
    fetch_halt_d = 1'b0;

    case (state)
      S_IDLE, S_HALT, S_FAULT: if (seq_start) nxt = S_FETCH;
      // The halt decision was captured on the way into FETCH so that the
      // registered pc_rd_en could already be withheld for this cycle.
      S_FETCH: nxt = fetch_halt ? S_HALT : S_MEMWAIT;
      S_MEMWAIT, S_OPWAIT: begin
        // mem_ready is tested first so it wins over a simultaneous timeout.
        if (mem_ready) begin
          nxt    = (state == S_MEMWAIT) ? S_LOADIR : S_JLOAD;
          to_nxt = 8'd0;
        end else if (to_cnt == TO_LAST) begin
          nxt    = S_FAULT;
          to_nxt = 8'd0;
        end else begin
          to_nxt = to_cnt + 8'd1;
        end
      end
      S_LOADIR: nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OPC_HALT)      nxt = S_HALT;
        else if (opcode == OPC_JMP)  nxt = S_OPFETCH;
        else if (opcode == OPC_BRZ)  nxt = flag_z ? S_BRLOAD : S_FETCH;
        else if (opcode == OPC_BSTEP) begin
          if (!flag_z && ir_in[3:0] != 4'd0) begin
            nxt      = S_STEP;
            step_nxt = ir_in[3:0];
          end else begin
            nxt = S_FETCH;
          end
        end else begin
          nxt = S_EXEC;
        end
      end
      S_OPFETCH:         nxt = S_OPWAIT;
      S_JLOAD, S_BRLOAD: nxt = S_FETCH;
      S_STEP: begin
        step_nxt = step_cnt - 4'd1;
        if (step_cnt == 4'd1) nxt = S_FETCH;
      end
      S_EXEC:   nxt = S_EXWAIT;
      S_EXWAIT: if (exec_done) nxt = S_FETCH;
      default:  nxt = S_IDLE;
    endcase

    case (nxt)
      S_FETCH: begin
        rd_d         = !seq_halt_req;
        fetch_halt_d = seq_halt_req;
      end
      S_MEMWAIT, S_OPWAIT: mrq_d = 1'b1;
      S_LOADIR: begin
        irl_d = 1'b1;
        cnt_d = 1'b1;
      end
      S_OPFETCH: rd_d = 1'b1;
      S_JLOAD:   wr_d = 1'b1;
      S_BRLOAD: begin
        wr_d   = 1'b1;
        lsel_d = 1'b1;
      end
      S_STEP: begin
        cnt_d = 1'b1;
        dir_d = 1'b1;
      end
      S_EXEC:  exs_d    = 1'b1;
      S_HALT:  halted_d = 1'b1;
      S_FAULT: fault_d  = 1'b1;
      default: ;
    endcase
    busy_d = (nxt != S_IDLE) && (nxt != S_HALT) && (nxt != S_FAULT);
  end

  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      state       <= S_IDLE;
      to_cnt      <= 8'd0;
      step_cnt    <= 4'd0;
      fetch_halt  <= 1'b0;
      pc_rd_en    <= 1'b0;
      pc_wr_en    <= 1'b0;
      pc_count    <= 1'b0;
      pc_dir      <= 1'b0;
      pc_load_sel <= 1'b0;
      mem_rd_req  <= 1'b0;
      ir_load     <= 1'b0;
      exec_start  <= 1'b0;
      seq_busy    <= 1'b0;
      seq_halted  <= 1'b0;
      seq_fault   <= 1'b0;
    end else begin
      state       <= nxt;
      to_cnt      <= to_nxt;
      step_cnt    <= step_nxt;
      fetch_halt  <= fetch_halt_d;
      pc_rd_en    <= rd_d;
      pc_wr_en    <= wr_d;
      pc_count    <= cnt_d;
      pc_dir      <= dir_d;
      pc_load_sel <= lsel_d;
      mem_rd_req  <= mrq_d;
      ir_load     <= irl_d;
      exec_start  <= exs_d;
      seq_busy    <= busy_d;
      seq_halted  <= halted_d;
      seq_fault   <= fault_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        seq_clk = 1'b0;
  logic        seq_rst_n = 1'b0;
  logic        seq_start = 1'b0;
  logic        seq_halt_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] ir_in = 16'h0000;
  logic        flag_z = 1'b0;
  logic        exec_done = 1'b0;
  logic        pc_rd_en, pc_wr_en, pc_count, pc_dir, pc_load_sel, mem_rd_req;
  logic        ir_load, exec_start, seq_busy, seq_halted, seq_fault;

  always #5 seq_clk = ~seq_clk;

  pc_sequencer #(.MEM_TIMEOUT(15), .OPC_W(4)) dut (
    .seq_clk(seq_clk), .seq_rst_n(seq_rst_n), .seq_start(seq_start),
    .seq_halt_req(seq_halt_req), .mem_ready(mem_ready), .ir_in(ir_in),
    .flag_z(flag_z), .exec_done(exec_done), .pc_rd_en(pc_rd_en),
    .pc_wr_en(pc_wr_en), .pc_count(pc_count), .pc_dir(pc_dir),
    .pc_load_sel(pc_load_sel), .mem_rd_req(mem_rd_req), .ir_load(ir_load),
    .exec_start(exec_start), .seq_busy(seq_busy), .seq_halted(seq_halted),
    .seq_fault(seq_fault)
  );

  localparam logic [10:0] RD  = 11'h400, WR  = 11'h200, CNT = 11'h100, DIR = 11'h080;
  localparam logic [10:0] LSL = 11'h040, MRQ = 11'h020, IRL = 11'h010, EXS = 11'h008;
  localparam logic [10:0] BSY = 11'h004, HLT = 11'h002, FLT = 11'h001;

  logic [10:0] obs;
  assign obs = {pc_rd_en, pc_wr_en, pc_count, pc_dir, pc_load_sel, mem_rd_req,
                ir_load, exec_start, seq_busy, seq_halted, seq_fault};

  int          checks = 0;
  int          errors = 0;
  string       phase = "reset";
  logic [10:0] exp_q[$];
  logic [10:0] exp_cur;

  // Program counter the strobes act on, plus event counters.
  logic [7:0] pc_q = 8'h00;
  logic [7:0] data_bus = 8'h00;
  int         step_cycles = 0;
  int         exec_pulses = 0;
  int         sb;

  always @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n)    pc_q <= 8'h00;
    else if (pc_wr_en) pc_q <= pc_load_sel ? ir_in[7:0] : data_bus;
    else if (pc_count) pc_q <= pc_dir ? pc_q - 8'd1 : pc_q + 8'd1;
  end

  always @(posedge seq_clk) begin
    if (pc_count && pc_dir) step_cycles <= step_cycles + 1;
    if (exec_start)         exec_pulses <= exec_pulses + 1;
  end

  // Single compare process: one expected output vector per queued cycle.
  always begin
    @(posedge seq_clk);
    #2;
    if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
      checks++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL trace[%s] t=%0t: got %b want %b", phase, $time, obs, exp_cur);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expect the state entered at the next rising edge to show vector e.
  task automatic tick(input logic [10:0] e);
    @(posedge seq_clk);
    exp_q.push_back(e);
    #1;
  endtask

  // FETCH (PC checked), lat+1 memory-wait cycles, IR load, decode.
  task automatic fetch_word(input logic [15:0] word, input int lat, input logic [7:0] exp_pc);
    tick(RD | BSY);
    chk({"fetch pc ", phase}, pc_q, exp_pc);
    seq_start = 1'b0; exec_done = 1'b0; mem_ready = 1'b0; flag_z = 1'b0;
    repeat (lat + 1) tick(MRQ | BSY);
    mem_ready = 1'b1;
    tick(IRL | CNT | BSY);
    mem_ready = 1'b0;
    ir_in = word;
    tick(BSY);
  endtask

  task automatic exec_tail(input int wait_cycles);
    tick(EXS | BSY);
    repeat (wait_cycles) tick(BSY);
    exec_done = 1'b1;
  endtask

  task automatic jmp_tail(input int lat, input logic [7:0] operand);
    tick(RD | BSY);
    repeat (lat + 1) tick(MRQ | BSY);
    mem_ready = 1'b1;
    data_bus = operand;
    tick(WR | BSY);
    mem_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge seq_clk);
    #1;
    chk("reset outputs", obs, 0);
    seq_rst_n = 1'b1;
    tick(11'h000);
    tick(11'h000);

    phase = "nop";
    seq_start = 1'b1;
    fetch_word(16'h1000, 2, 8'h00);
    seq_start = 1'b1;
    exec_tail(2);

    phase = "jmp";
    fetch_word(16'hE000, 1, 8'h01);
    jmp_tail(1, 8'h42);

    phase = "brz_taken";
    fetch_word(16'hD037, 1, 8'h42);
    flag_z = 1'b1;
    tick(WR | LSL | BSY);
    flag_z = 1'b0;

    phase = "brz_not_taken";
    fetch_word(16'hD037, 0, 8'h37);

    phase = "bstep3";
    fetch_word(16'hC003, 0, 8'h38);
    sb = step_cycles;
    repeat (3) tick(CNT | DIR | BSY);

    phase = "bstep_z";
    fetch_word(16'hC003, 0, 8'h36);
    chk("bstep decrement cycles", step_cycles - sb, 3);
    flag_z = 1'b1;

    phase = "bstep0";
    fetch_word(16'hC000, 0, 8'h37);

    phase = "halt_req";
    fetch_word(16'h2ABC, 0, 8'h38);
    tick(EXS | BSY);
    tick(BSY);
    seq_halt_req = 1'b1;
    tick(BSY);
    exec_done = 1'b1;
    tick(BSY);
    exec_done = 1'b0;
    tick(HLT);
    seq_halt_req = 1'b0;
    tick(HLT);
    chk("pc after halt", pc_q, 8'h39);

    phase = "halt_opcode";
    seq_start = 1'b1;
    fetch_word(16'hF000, 0, 8'h39);
    tick(HLT);
    tick(HLT);

    phase = "ready_at_timeout";
    seq_start = 1'b1;
    fetch_word(16'h3000, 14, 8'h3A);
    exec_tail(1);

    phase = "timeout";
    tick(RD | BSY);
    chk("fetch pc timeout", pc_q, 8'h3B);
    exec_done = 1'b0;
    repeat (15) tick(MRQ | BSY);
    repeat (3) tick(FLT);
    seq_start = 1'b1;

    phase = "reset_exwait";
    fetch_word(16'h1000, 0, 8'h3B);
    tick(EXS | BSY);
    tick(BSY);
    #4;
    seq_rst_n = 1'b0;
    #1;
    chk("async reset outputs", obs, 0);
    @(posedge seq_clk);
    #1;
    chk("reset held outputs", obs, 0);
    seq_start = 1'b1;
    seq_rst_n = 1'b1;
    fetch_word(16'h1000, 0, 8'h00);
    exec_tail(1);
    tick(RD | BSY);
    chk("fetch pc final", pc_q, 8'h01);
    exec_done = 1'b0;

    @(posedge seq_clk);
    #3;
    chk("trace drained", exp_q.size(), 0);
    chk("exec_start pulses", exec_pulses, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
